// File: rtl/regfile_writeback.sv
// Write-port controller for the 32x32 register bank: merges ALU results with in-order load returns,
// tracks pending load destinations per register and flags decode RAW hazards. Optional: WB_PERF_EN.
module regfile_writeback #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_issue,
   input  logic [4:0]  ld_issue_rd,
   output logic        issue_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard_a,
   output logic        hazard_b,
   output logic        rf_we,
   output logic [4:0]  rf_select_d,
   output logic [31:0] rf_input_d,
`ifdef WB_PERF_EN
   output logic [31:0] ld_wait_cycles,
`endif
   output logic        err
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned RW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NREG = 32;

   logic [RW-1:0] tag_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] tag_wr, tag_rd, data_wr, data_rd;
   logic [CW-1:0] tag_cnt, data_cnt, out_cnt;
   logic [CW-1:0] sb_count [NREG];
   logic          ld_done;

   logic issue_acc, issue_err, ret_acc, ret_err, pop, waw_err;

   // Outstanding = tags not yet popped plus a load write currently on the bank port.
   assign issue_ready = (out_cnt < CW'(DEPTH));
   assign issue_acc   = ld_issue & issue_ready;
   assign issue_err   = ld_issue & ~issue_ready;
   assign ret_err     = ld_valid & (data_cnt >= tag_cnt);
   assign ret_acc     = ld_valid & ~ret_err;
   assign pop         = ~alu_valid & (data_cnt != '0);
   assign waw_err     = alu_valid & (sb_count[alu_rd] != '0);
   assign hazard_a    = (rs1 != '0) & (sb_count[rs1] != '0);
   assign hazard_b    = (rs2 != '0) & (sb_count[rs2] != '0);

   // FIFO storage, no reset needed: occupancy counters qualify every read.
   always_ff @(posedge clock) begin
      if (issue_acc) tag_mem[tag_wr] <= ld_issue_rd;
      if (ret_acc)   data_mem[data_wr] <= ld_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_wr   <= '0;
         tag_rd   <= '0;
         data_wr  <= '0;
         data_rd  <= '0;
         tag_cnt  <= '0;
         data_cnt <= '0;
         out_cnt  <= '0;
      end else begin
         if (issue_acc) tag_wr <= tag_wr + 1'b1;
         if (ret_acc)   data_wr <= data_wr + 1'b1;
         if (pop) begin
            tag_rd  <= tag_rd + 1'b1;
            data_rd <= data_rd + 1'b1;
         end
         tag_cnt  <= tag_cnt + CW'(issue_acc) - CW'(pop);
         data_cnt <= data_cnt + CW'(ret_acc) - CW'(pop);
         out_cnt  <= out_cnt + CW'(issue_acc) - CW'(ld_done);
      end
   end

   // Bank write port: ALU has priority, otherwise drain the oldest returned load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rf_we       <= 1'b0;
         rf_select_d <= '0;
         rf_input_d  <= '0;
         ld_done     <= 1'b0;
      end else if (alu_valid) begin
         rf_we       <= (alu_rd != '0);
         rf_select_d <= alu_rd;
         rf_input_d  <= alu_data;
         ld_done     <= 1'b0;
      end else if (pop) begin
         rf_we       <= (tag_mem[tag_rd] != '0);
         rf_select_d <= tag_mem[tag_rd];
         rf_input_d  <= data_mem[data_rd];
         ld_done     <= 1'b1;
      end else begin
         rf_we   <= 1'b0;
         ld_done <= 1'b0;
      end
   end

   // Scoreboard: a load's count drops at the end of its bank-write cycle; x0 never counts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) sb_count[i] <= '0;
      end else begin
         sb_count[0] <= '0;
         for (int i = 1; i < int'(NREG); i++)
            sb_count[i] <= sb_count[i]
                           + CW'(issue_acc && (ld_issue_rd == RW'(i)))
                           - CW'(ld_done && (rf_select_d == RW'(i)));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) err <= 1'b0;
      else       err <= err | issue_err | ret_err | waw_err;
   end

`ifdef WB_PERF_EN
   // Cycles where returned load data sat waiting behind an ALU write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          ld_wait_cycles <= '0;
      else if (alu_valid && data_cnt != '0) ld_wait_cycles <= ld_wait_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: inputs change and outputs are checked at the falling edge.
module tb_regfile_writeback;
   logic        clock = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        issue_ready;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [4:0]  rs1, rs2;
   logic        hazard_a, hazard_b;
   logic        rf_we;
   logic [4:0]  rf_select_d;
   logic [31:0] rf_input_d;
   logic        err;
`ifdef WB_PERF_EN
   logic [31:0] ld_wait_cycles;
`endif

   int checks = 0;
   int errors = 0;

   regfile_writeback #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .issue_ready(issue_ready),
      .ld_valid(ld_valid), .ld_data(ld_data),
      .rs1(rs1), .rs2(rs2), .hazard_a(hazard_a), .hazard_b(hazard_b),
      .rf_we(rf_we), .rf_select_d(rf_select_d), .rf_input_d(rf_input_d),
`ifdef WB_PERF_EN
      .ld_wait_cycles(ld_wait_cycles),
`endif
      .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to the middle of the next cycle and clear the one-shot strobes.
   task automatic cyc();
      @(negedge clock);
      alu_valid = 1'b0;
      ld_issue  = 1'b0;
      ld_valid  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_data = '0;
      rs1 = 5'd7; rs2 = '0;

      // Reset state
      cyc(); #1;
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_sel", 32'(rf_select_d), 32'd0);
      chk("rst_data", rf_input_d, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_haz", 32'(hazard_a), 32'd0);
      cyc(); reset = 1'b0;

      // ALU only
      cyc(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cyc(); #1;
      chk("alu_we", 32'(rf_we), 32'd1);
      chk("alu_sel", 32'(rf_select_d), 32'd5);
      chk("alu_data", rf_input_d, 32'hDEADBEEF);
      cyc(); #1;
      chk("alu_we_off", 32'(rf_we), 32'd0);

      // Load hazard: issue c0, return c3, write c5, hazard clear c6
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7; #1;
      chk("lh_haz_c0", 32'(hazard_a), 32'd0);
      cyc(); #1;
      chk("lh_haz_c1", 32'(hazard_a), 32'd1);
      cyc();
      cyc(); ld_valid = 1'b1; ld_data = 32'h1234;
      cyc(); #1;
      chk("lh_we_c4", 32'(rf_we), 32'd0);
      cyc(); #1;
      chk("lh_we_c5", 32'(rf_we), 32'd1);
      chk("lh_sel_c5", 32'(rf_select_d), 32'd7);
      chk("lh_data_c5", rf_input_d, 32'h1234);
      chk("lh_haz_c5", 32'(hazard_a), 32'd1);
      cyc(); #1;
      chk("lh_haz_c6", 32'(hazard_a), 32'd0);
      chk("lh_err", 32'(err), 32'd0);

      // Contention: load data c2, ALU c2..c4, load written c6
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd3; rs2 = 5'd3;
      cyc(); #1;
      chk("ct_hazb", 32'(hazard_b), 32'd1);
      cyc(); ld_valid = 1'b1; ld_data = 32'hCAFE0003;
             alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0A;
      cyc(); alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0B; #1;
      chk("ct_sel_c3", 32'(rf_select_d), 32'd10);
      cyc(); alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0C; #1;
      chk("ct_sel_c4", 32'(rf_select_d), 32'd11);
      cyc(); #1;
      chk("ct_sel_c5", 32'(rf_select_d), 32'd12);
      chk("ct_data_c5", rf_input_d, 32'h0C);
      cyc(); #1;
      chk("ct_we_c6", 32'(rf_we), 32'd1);
      chk("ct_sel_c6", 32'(rf_select_d), 32'd3);
      chk("ct_data_c6", rf_input_d, 32'hCAFE0003);
      cyc(); #1;
      chk("ct_we_c7", 32'(rf_we), 32'd0);
      chk("ct_hazb_c7", 32'(hazard_b), 32'd0);
`ifdef WB_PERF_EN
      chk("ct_wait", ld_wait_cycles, 32'd2);
`endif

      // Full: four issues, fifth is an error
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd1;
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd2;
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd4;
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd6; #1;
      chk("fu_ready_c3", 32'(issue_ready), 32'd1);
      cyc(); #1;
      chk("fu_ready_c4", 32'(issue_ready), 32'd0);
      chk("fu_err_c4", 32'(err), 32'd0);
      ld_issue = 1'b1; ld_issue_rd = 5'd8;
      cyc(); rs1 = 5'd8; ld_valid = 1'b1; ld_data = 32'h11; #1;
      chk("fu_err_c5", 32'(err), 32'd1);
      chk("fu_haz8", 32'(hazard_a), 32'd0);
      chk("fu_ready_c5", 32'(issue_ready), 32'd0);
      cyc();
      cyc(); rs1 = 5'd1; #1;
      chk("fu_we_c7", 32'(rf_we), 32'd1);
      chk("fu_sel_c7", 32'(rf_select_d), 32'd1);
      chk("fu_ready_c7", 32'(issue_ready), 32'd0);
      chk("fu_haz1_c7", 32'(hazard_a), 32'd1);
      cyc(); ld_valid = 1'b1; ld_data = 32'h22; #1;
      chk("fu_ready_c8", 32'(issue_ready), 32'd1);
      chk("fu_haz1_c8", 32'(hazard_a), 32'd0);
      cyc(); ld_valid = 1'b1; ld_data = 32'h44;
      cyc(); ld_valid = 1'b1; ld_data = 32'h66; #1;
      chk("fu_sel_c10", 32'(rf_select_d), 32'd2);
      cyc();
      cyc(); #1;
      chk("fu_sel_c12", 32'(rf_select_d), 32'd6);
      chk("fu_data_c12", rf_input_d, 32'h66);
      cyc(); reset = 1'b1; #1;
      chk("fu_err_rst", 32'(err), 32'd0);
      cyc(); reset = 1'b0;

      // x0 loads: pop normally, never write
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd0;
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd0;
      cyc(); ld_valid = 1'b1; ld_data = 32'hAA;
      cyc(); ld_valid = 1'b1; ld_data = 32'hBB;
      cyc(); #1;
      chk("x0_we_c4", 32'(rf_we), 32'd0);
      cyc(); #1;
      chk("x0_we_c5", 32'(rf_we), 32'd0);
      cyc(); #1;
      chk("x0_err", 32'(err), 32'd0);
      chk("x0_ready", 32'(issue_ready), 32'd1);

      // Duplicate rd=9: hazard until the second write-back
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd9; rs1 = 5'd9;
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd9;
      cyc();
      cyc(); ld_valid = 1'b1; ld_data = 32'h9A;
      cyc(); ld_valid = 1'b1; ld_data = 32'h9B;
      cyc(); #1;
      chk("dup_data_c5", rf_input_d, 32'h9A);
      chk("dup_haz_c5", 32'(hazard_a), 32'd1);
      cyc(); #1;
      chk("dup_data_c6", rf_input_d, 32'h9B);
      chk("dup_sel_c6", 32'(rf_select_d), 32'd9);
      chk("dup_haz_c6", 32'(hazard_a), 32'd1);
      cyc(); #1;
      chk("dup_haz_c7", 32'(hazard_a), 32'd0);

      // WAW with pending load, then reset with three loads outstanding
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd13;
      cyc(); alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h55; #1;
      chk("waw_err_pre", 32'(err), 32'd0);
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd14; #1;
      chk("waw_we", 32'(rf_we), 32'd1);
      chk("waw_sel", 32'(rf_select_d), 32'd13);
      chk("waw_err", 32'(err), 32'd1);
      cyc(); ld_issue = 1'b1; ld_issue_rd = 5'd15; rs1 = 5'd14;
      cyc(); #1;
      chk("mr_haz_pre", 32'(hazard_a), 32'd1);
      reset = 1'b1; #1;
      chk("mr_we", 32'(rf_we), 32'd0);
      chk("mr_sel", 32'(rf_select_d), 32'd0);
      chk("mr_data", rf_input_d, 32'd0);
      chk("mr_err", 32'(err), 32'd0);
      chk("mr_ready", 32'(issue_ready), 32'd1);
      chk("mr_haz", 32'(hazard_a), 32'd0);
`ifdef WB_PERF_EN
      chk("mr_wait", ld_wait_cycles, 32'd0);
`endif
      cyc(); reset = 1'b0;
      cyc(); ld_valid = 1'b1; ld_data = 32'h77;
      cyc(); #1;
      chk("mr_ret_err", 32'(err), 32'd1);
      cyc(); #1;
      chk("mr_ret_drop", 32'(rf_we), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
